vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
Parametrised VGA raster timing generator. It is the successor to the fixed 640x480 controller. Timing, sync polarity and pixel-clock division are all set by parameters. A pixel-rate tick is generated internally, and all raster outputs are registered and mutually aligned. It also provides line-start and frame-start strobes, a frame counter and an enable input for the pixel-pipeline and framebuffer readers.

Parameters:
HD, 640, horizontal display pixels
HF, 16, horizontal front porch (follows display)
HS, 96, horizontal sync width (follows front porch)
HB, 48, horizontal back porch (follows sync)
VD, 480, vertical display lines
VF, 10, vertical front porch
VS, 2, vertical sync width
VB, 33, vertical back porch
HSYNC_POL, 0, active level of hsync (0 = active-low)
VSYNC_POL, 0, active level of vsync
CLK_DIV, 2, clk_50MHz cycles per pixel (>=1)
CW, 12, width of x/y counters; HTOTAL=HD+HF+HS+HB and VTOTAL=VD+VF+VS+VB must be <= 2^CW
FW, 16, frame counter width

Ports:
clk_50MHz  in  1  system clock; all state on its rising edge
reset  in  1  asynchronous, active-low reset (0 = reset)
en  in  1  run enable; 0 freezes all counters and outputs
pix_tick  out  1  one-clock pulse marking a pixel advance
x  out  CW  current horizontal position, 0..HTOTAL-1
y  out  CW  current vertical position, 0..VTOTAL-1
video_on  out  1  1 while x<HD and y<VD
hsync  out  1  horizontal sync at HSYNC_POL level while HD+HF <= x < HD+HF+HS
vsync  out  1  vertical sync at VSYNC_POL level while VD+VF <= y < VD+VF+VS
line_start  out  1  one-clock pulse when x becomes 0
frame_start  out  1  one-clock pulse when (x,y) becomes (0,0)
frame_count  out  FW  frames started since reset, wraps modulo 2^FW

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - div_cnt=0, x=HTOTAL-1, y=VTOTAL-1.
  - video_on=0; hsync=~HSYNC_POL; vsync=~VSYNC_POL.
  - line_start=0, frame_start=0, frame_count=0.
  - These values are the correct decode of the last raster position, so the first tick lands on (0,0).
- Divider:
  - div_cnt counts 0..CLK_DIV-1 and advances only while en=1.
  - pix_tick = en && (div_cnt==CLK_DIV-1), decoded from the register with no extra delay.
  - CLK_DIV=1 gives pix_tick=en every cycle.
- Raster advance on the clock edge that ends a pix_tick cycle:
  - x <= (x==HTOTAL-1) ? 0 : x+1.
  - y advances only when x wraps: y <= (y==VTOTAL-1) ? 0 : y+1.
- Registered decodes:
  - video_on, hsync and vsync are registered from the next x/y values, so they are always consistent with the x/y presented in the same cycle (zero skew, one register stage).
- Strobes:
  - line_start is high for exactly the one clock after an edge that sets x=0.
  - frame_start is likewise high for the one clock after an edge that sets x=0 and y=0; line_start is also high in that clock.
  - Neither strobe may repeat while en is held low.
- frame_count increments on the same edge that raises frame_start, wrapping from 2^FW-1 to 0.
- en=0: everything holds, including div_cnt, and strobes drop to 0 on the next edge. On en returning to 1, counting resumes from the held div_cnt.
- Reset mid-frame: outputs return immediately (asynchronously) to reset values; no partial strobe survives.
- Width rules:
  - Comparisons are unsigned, on CW bits.
  - Parameter sums are evaluated as int.
  - Elaboration fails (assertion) if CLK_DIV<1, any of HD/HS/VD/VS is 0, or HTOTAL/VTOTAL > 2^CW.

Test Plan:
- Defaults, release reset, en=1 -> first pix_tick at the 2nd clock; next cycle x=0, y=0, frame_start=1, line_start=1, frame_count=1, video_on=1.
- Defaults, run one line -> hsync=0 exactly for x=656..751 (96 ticks); video_on falls at x=640; line_start period is 800 ticks = 1600 clocks.
- Defaults, run a full frame -> vsync=0 exactly for y=490..491; video_on=0 for y>=480; frame_start period is 420000 ticks; frame_count=2 at the 2nd frame start.
- en dropped for 37 clocks mid-line at x=100 -> x, y, div_cnt and outputs frozen with no strobes; after resume the line completes with total line length 800 ticks.
- Override CLK_DIV=1, HD=8, HF=1, HS=2, HB=1, VD=4, VF=1, VS=1, VB=1, HSYNC_POL=1, FW=2 -> hsync=1 for x=9..10; frame every 12*7=84 clocks; frame_count sequence 1,2,3,0,1.
- Assert reset at x=300, y=200 -> immediate x=HTOTAL-1, y=VTOTAL-1, video_on=0, syncs inactive, frame_count=0; after release the first tick gives (0,0) with frame_start.

Source files
------------

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA raster timing generator; in clk_50MHz, reset (async active-low), en; out pix_tick, x, y, video_on, hsync, vsync, line_start, frame_start, frame_count
module vga_timing_gen #(
  parameter int HD = 640,
  parameter int HF = 16,
  parameter int HS = 96,
  parameter int HB = 48,
  parameter int VD = 480,
  parameter int VF = 10,
  parameter int VS = 2,
  parameter int VB = 33,
  parameter int HSYNC_POL = 0,
  parameter int VSYNC_POL = 0,
  parameter int CLK_DIV = 2,
  parameter int CW = 12,
  parameter int FW = 16
) (
  input  logic          clk_50MHz,
  input  logic          reset,
  input  logic          en,
  output logic          pix_tick,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          video_on,
  output logic          hsync,
  output logic          vsync,
  output logic          line_start,
  output logic          frame_start,
  output logic [FW-1:0] frame_count
);
  localparam int HT = HD + HF + HS + HB;
  localparam int VT = VD + VF + VS + VB;
  localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] X_LAST = CW'(HT - 1);
  localparam logic [CW-1:0] Y_LAST = CW'(VT - 1);
  if (CLK_DIV < 1 || HD == 0 || HS == 0 || VD == 0 || VS == 0 || HT > 2**CW || VT > 2**CW) begin : g_bad_params
    $error("vga_timing_gen: illegal parameter set");
  end
  logic [DW-1:0] div_q, div_d;
  logic [CW-1:0] x_q, x_d, y_q, y_d;
  logic [FW-1:0] fc_q, fc_d;
  logic video_q, video_d, hsync_q, hsync_d, vsync_q, vsync_d;
  logic line_q, line_d, frame_q, frame_d, x_wrap;
  always_comb begin
    pix_tick = en && div_q == DW'(CLK_DIV - 1);
    x_wrap = pix_tick && x_q == X_LAST;
    div_d = !en ? div_q : pix_tick ? '0 : div_q + 1'b1;
    x_d = !pix_tick ? x_q : x_wrap ? '0 : x_q + 1'b1;
    y_d = !x_wrap ? y_q : y_q == Y_LAST ? '0 : y_q + 1'b1;
    video_d = int'(x_d) < HD && int'(y_d) < VD;
    hsync_d = (int'(x_d) >= HD + HF && int'(x_d) < HD + HF + HS) ? HSYNC_POL[0] : !HSYNC_POL[0];
    vsync_d = (int'(y_d) >= VD + VF && int'(y_d) < VD + VF + VS) ? VSYNC_POL[0] : !VSYNC_POL[0];
    line_d = x_wrap;
    frame_d = x_wrap && y_q == Y_LAST;
    fc_d = fc_q + FW'(frame_d);
  end
  always_ff @(posedge clk_50MHz or negedge reset) begin
    if (!reset) begin
      div_q <= '0;
      x_q <= X_LAST;
      y_q <= Y_LAST;
      video_q <= 1'b0;
      hsync_q <= !HSYNC_POL[0];
      vsync_q <= !VSYNC_POL[0];
      line_q <= 1'b0;
      frame_q <= 1'b0;
      fc_q <= '0;
    end else begin
      div_q <= div_d;
      x_q <= x_d;
      y_q <= y_d;
      video_q <= video_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      line_q <= line_d;
      frame_q <= frame_d;
      fc_q <= fc_d;
    end
  end
  assign x = x_q;
  assign y = y_q;
  assign video_on = video_q;
  assign hsync = hsync_q;
  assign vsync = vsync_q;
  assign line_start = line_q;
  assign frame_start = frame_q;
  assign frame_count = fc_q;
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: scoreboard bench for three vga_timing_gen configurations against an arithmetic raster model
module tb_vga_timing_gen;
  typedef struct packed {int d, hd, hf, hs, hb, vd, vf, vs, vb, hp, vp, fw;} cfg_t;
  typedef struct packed {int tick, x, y, vid, hs, vs, ls, fs, fc;} exp_t;
  localparam cfg_t CA = '{d:2, hd:640, hf:16, hs:96, hb:48, vd:480, vf:10, vs:2, vb:33, hp:0, vp:0, fw:16};
  localparam cfg_t CB = '{d:1, hd:8, hf:1, hs:2, hb:1, vd:4, vf:1, vs:1, vb:1, hp:1, vp:0, fw:2};
  localparam cfg_t CC = '{d:3, hd:5, hf:2, hs:3, hb:2, vd:3, vf:2, vs:2, vb:1, hp:0, vp:1, fw:3};
  logic clk = 1'b0, rst_n = 1'b0, en = 1'b0;
  logic a_tick, a_vid, a_hs, a_vs, a_ls, a_fs;
  logic [11:0] a_x, a_y;
  logic [15:0] a_fc;
  logic b_tick, b_vid, b_hs, b_vs, b_ls, b_fs;
  logic [3:0] b_x, b_y;
  logic [1:0] b_fc;
  logic c_tick, c_vid, c_hs, c_vs, c_ls, c_fs;
  logic [3:0] c_x, c_y;
  logic [2:0] c_fc;
  int checks = 0, errors = 0, ec = 0, cyc = 0;
  bit pe = 1'b0;
  exp_t qa[$], qb[$], qc[$];
  exp_t ea, eb, ecc;
  always #5 clk = ~clk;
  vga_timing_gen #(.HD(CA.hd), .HF(CA.hf), .HS(CA.hs), .HB(CA.hb), .VD(CA.vd), .VF(CA.vf), .VS(CA.vs), .VB(CA.vb),
    .HSYNC_POL(CA.hp), .VSYNC_POL(CA.vp), .CLK_DIV(CA.d), .CW(12), .FW(CA.fw)) u_a (
    .clk_50MHz(clk), .reset(rst_n), .en(en), .pix_tick(a_tick), .x(a_x), .y(a_y), .video_on(a_vid),
    .hsync(a_hs), .vsync(a_vs), .line_start(a_ls), .frame_start(a_fs), .frame_count(a_fc));
  vga_timing_gen #(.HD(CB.hd), .HF(CB.hf), .HS(CB.hs), .HB(CB.hb), .VD(CB.vd), .VF(CB.vf), .VS(CB.vs), .VB(CB.vb),
    .HSYNC_POL(CB.hp), .VSYNC_POL(CB.vp), .CLK_DIV(CB.d), .CW(4), .FW(CB.fw)) u_b (
    .clk_50MHz(clk), .reset(rst_n), .en(en), .pix_tick(b_tick), .x(b_x), .y(b_y), .video_on(b_vid),
    .hsync(b_hs), .vsync(b_vs), .line_start(b_ls), .frame_start(b_fs), .frame_count(b_fc));
  vga_timing_gen #(.HD(CC.hd), .HF(CC.hf), .HS(CC.hs), .HB(CC.hb), .VD(CC.vd), .VF(CC.vf), .VS(CC.vs), .VB(CC.vb),
    .HSYNC_POL(CC.hp), .VSYNC_POL(CC.vp), .CLK_DIV(CC.d), .CW(4), .FW(CC.fw)) u_c (
    .clk_50MHz(clk), .reset(rst_n), .en(en), .pix_tick(c_tick), .x(c_x), .y(c_y), .video_on(c_vid),
    .hsync(c_hs), .vsync(c_vs), .line_start(c_ls), .frame_start(c_fs), .frame_count(c_fc));
  function automatic exp_t model(cfg_t c, int n_en, bit prev_en, bit e);
    int ht = c.hd + c.hf + c.hs + c.hb;
    int vt = c.vd + c.vf + c.vs + c.vb;
    int n = ht * vt;
    int p = n_en / c.d;
    int pos = (p + n - 1) % n;
    exp_t r;
    r.tick = (e && n_en % c.d == c.d - 1) ? 1 : 0;
    r.x = pos % ht;
    r.y = pos / ht;
    r.vid = (r.x < c.hd && r.y < c.vd) ? 1 : 0;
    r.hs = (r.x >= c.hd + c.hf && r.x < c.hd + c.hf + c.hs) ? c.hp : 1 - c.hp;
    r.vs = (r.y >= c.vd + c.vf && r.y < c.vd + c.vf + c.vs) ? c.vp : 1 - c.vp;
    r.ls = (prev_en && n_en > 0 && n_en % c.d == 0 && r.x == 0) ? 1 : 0;
    r.fs = (r.ls == 1 && r.y == 0) ? 1 : 0;
    r.fc = (p == 0 ? 0 : (p - 1) / n + 1) % (1 << c.fw);
    return r;
  endfunction
  task automatic chk(string nm, int act, int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s cyc=%0d: got %0d, expected %0d", nm, cyc, act, req);
    end
  endtask
  task automatic chk_all(string id, exp_t e, int tk, int xx, int yy, int vd, int hs, int vs, int ls, int fs, int fc);
    chk({id, ".pix_tick"}, tk, e.tick);
    chk({id, ".x"}, xx, e.x);
    chk({id, ".y"}, yy, e.y);
    chk({id, ".video_on"}, vd, e.vid);
    chk({id, ".hsync"}, hs, e.hs);
    chk({id, ".vsync"}, vs, e.vs);
    chk({id, ".line_start"}, ls, e.ls);
    chk({id, ".frame_start"}, fs, e.fs);
    chk({id, ".frame_count"}, fc, e.fc);
  endtask
  always @(negedge clk) begin
    if (qa.size() > 0) begin
      ea = qa.pop_front();
      chk_all("A", ea, int'(a_tick), int'(a_x), int'(a_y), int'(a_vid), int'(a_hs), int'(a_vs), int'(a_ls), int'(a_fs), int'(a_fc));
    end
    if (qb.size() > 0) begin
      eb = qb.pop_front();
      chk_all("B", eb, int'(b_tick), int'(b_x), int'(b_y), int'(b_vid), int'(b_hs), int'(b_vs), int'(b_ls), int'(b_fs), int'(b_fc));
    end
    if (qc.size() > 0) begin
      ecc = qc.pop_front();
      chk_all("C", ecc, int'(c_tick), int'(c_x), int'(c_y), int'(c_vid), int'(c_hs), int'(c_vs), int'(c_ls), int'(c_fs), int'(c_fc));
    end
  end
  task automatic step(input bit r, input bit e);
    @(posedge clk);
    #1;
    cyc++;
    if (rst_n) begin
      if (en) ec++;
      pe = en;
    end
    rst_n = r;
    en = e;
    if (!r) begin
      ec = 0;
      pe = 1'b0;
    end
    qa.push_back(model(CA, ec, pe, e));
    qb.push_back(model(CB, ec, pe, e));
    qc.push_back(model(CC, ec, pe, e));
  endtask
  initial begin
    int guard;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
    guard = 0;
    while (model(CA, ec, pe, 1'b1).x != 100 && guard < 2000) begin
      step(1'b1, 1'b1);
      guard++;
    end
    if (guard >= 2000) begin
      errors++;
      $display("FAIL freeze_point: x=100 not reached in %0d cycles", guard);
    end
    for (int i = 0; i < 37; i++) step(1'b1, 1'b0);
    for (int i = 0; i < 4000; i++) begin
      if (i >= 2500 && i < 2502) step(1'b0, 1'b0);
      else step(1'b1, $urandom_range(0, 7) != 0);
    end
    for (int i = 0; i < 3200; i++) step(1'b1, 1'b1);
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
